// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions: generator polynomial, single-bit update and
// checker state encoding. Used by crc8, crc8_shift_unit and crc8_checker.
package crc8_pkg;

  // Generator polynomial, MSB-first, implicit x^8 term.
  localparam logic [7:0] CRC8_POLY = 8'h8B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One bit-serial CRC step: feedback is the outgoing MSB xor the incoming bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_shift_unit.sv
// Bit-serial CRC-8 engine: CRC register, byte shift register and bit counter.
// load seeds the CRC, byte_load latches a new byte, step consumes its MSB.
module crc8_shift_unit
  import crc8_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       byte_load,
  input  logic [7:0] byte_val,
  input  logic       step,
  output logic [7:0] crc,
  output logic       last_bit
);

  logic [7:0] crc_r;
  logic [7:0] byte_r;
  logic [2:0] bit_cnt_r;

  // CRC register: seed on load, advance one bit per step.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      crc_r <= 8'h00;
    end else if (load) begin
      crc_r <= load_val;
    end else if (step) begin
      crc_r <= crc8_step(crc_r, byte_r[7]);
    end else begin
      crc_r <= crc_r;
    end
  end

  // Byte shift register and bit counter: MSB is always the next bit to consume.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      byte_r    <= 8'h00;
      bit_cnt_r <= 3'd0;
    end else if (byte_load) begin
      byte_r    <= byte_val;
      bit_cnt_r <= 3'd0;
    end else if (step) begin
      byte_r    <= {byte_r[6:0], 1'b0};
      bit_cnt_r <= bit_cnt_r + 3'd1;
    end else begin
      byte_r    <= byte_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  assign crc      = crc_r;
  assign last_bit = (bit_cnt_r == 3'd7);

endmodule

// File: rtl/crc8_checker.sv
// Receive-side CRC-8 checker: recomputes the CRC over a frame's data bytes
// bit-serially and compares it with the trailing CRC byte.
module crc8_checker
  import crc8_pkg::*;
#(
  parameter int MAX_BYTES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [7:0]                       init_val,
  input  logic                             start_i,
  input  logic [7:0]                       data_i,
  input  logic                             valid_i,
  input  logic                             last_i,
  output logic                             ready_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             ok_o,
  output logic                             err_o,
  output logic                             ovf_o,
  output logic [7:0]                       crc_o,
  output logic [$clog2(MAX_BYTES+1)-1:0]   len_o
);

  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  state_t     state_r;
  state_t     state_next_s;
  logic       load_s;
  logic       byte_load_s;
  logic       step_s;
  logic       len_inc_s;
  logic       ovf_set_s;
  logic       rx_load_s;
  logic       check_s;
  logic       last_bit_s;
  logic [7:0] crc_s;
  logic [7:0] rx_crc_r;
  logic       match_s;

  crc8_shift_unit u_shift (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (load_s),
    .load_val  (init_val),
    .byte_load (byte_load_s),
    .byte_val  (data_i),
    .step      (step_s),
    .crc       (crc_s),
    .last_bit  (last_bit_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control strobes; start_i overrides everything else.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    byte_load_s  = 1'b0;
    step_s       = 1'b0;
    len_inc_s    = 1'b0;
    ovf_set_s    = 1'b0;
    rx_load_s    = 1'b0;
    check_s      = 1'b0;
    if (start_i) begin
      load_s       = 1'b1;
      state_next_s = ST_WAIT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_IDLE;
        end
        ST_WAIT: begin
          if (valid_i) begin
            if (last_i) begin
              rx_load_s    = 1'b1;
              state_next_s = ST_CHECK;
            end else if (len_o == MAX_LEN) begin
              // Byte is dropped, not shifted; frame continues to its CRC byte.
              ovf_set_s    = 1'b1;
              state_next_s = ST_WAIT;
            end else begin
              byte_load_s  = 1'b1;
              len_inc_s    = 1'b1;
              state_next_s = ST_SHIFT;
            end
          end else begin
            state_next_s = ST_WAIT;
          end
        end
        ST_SHIFT: begin
          step_s = 1'b1;
          if (last_bit_s) begin
            state_next_s = ST_WAIT;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end
        ST_CHECK: begin
          check_s      = 1'b1;
          state_next_s = ST_DONE;
        end
        ST_DONE: begin
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  assign match_s = (crc_s == rx_crc_r) && !ovf_o;

  // Received CRC byte capture.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rx_crc_r <= 8'h00;
    end else if (rx_load_s) begin
      rx_crc_r <= data_i;
    end else begin
      rx_crc_r <= rx_crc_r;
    end
  end

  // Handshake/status outputs decoded from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      ready_o <= (state_next_s == ST_WAIT);
      busy_o  <= (state_next_s != ST_IDLE);
      done_o  <= (state_next_s == ST_DONE);
    end
  end

  // Verdict flags and length counter, cleared at frame start and held afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ok_o  <= 1'b0;
      err_o <= 1'b0;
      ovf_o <= 1'b0;
      len_o <= '0;
    end else if (load_s) begin
      ok_o  <= 1'b0;
      err_o <= 1'b0;
      ovf_o <= 1'b0;
      len_o <= '0;
    end else begin
      ovf_o <= ovf_o | ovf_set_s;
      len_o <= len_inc_s ? (len_o + LEN_W'(1)) : len_o;
      ok_o  <= check_s ? match_s : ok_o;
      err_o <= check_s ? !match_s : err_o;
    end
  end

  assign crc_o = crc_s;

endmodule
